ao486_io_wb_bridge: RTL and testbench
=====================================

// Module: ao486_io_wb_bridge
// PURPOSE
//  Master-side bridge: converts ao486 port-I/O requests (io_read_*/io_write_*, 16-bit port address, 1-4 bytes, any alignment)
//  into 32-bit Wishbone classic cycles. Sits upstream of the I/O Wishbone slave/bus model. Handles lane steering,
//  word-crossing splits, err/rty handling and a bus timeout.
// PARAMETERS
//  IO_BASE      32'h0000_0000  added to the word-aligned port address to form wb_adr_o
//  MAX_RTY      3              rty retries per bus cycle before the cycle is treated as err
//  TIMEOUT      255            clocks with cyc high and no ack/err/rty before the cycle is treated as err (8-bit counter)
// PORTS
//  wb_clk_i          in   1   clock, all logic on rising edge
//  wb_rst_n_i        in   1   synchronous reset, active low
//  io_read_do        in   1   read request, level, held until io_read_done
//  io_read_address   in   16  port address
//  io_read_length    in   3   byte count, 1..4
//  io_read_data      out  32  read data, LSB-aligned, valid with io_read_done
//  io_read_done      out  1   one-cycle completion pulse
//  io_write_do       in   1   write request, level, held until io_write_done
//  io_write_address  in   16  port address
//  io_write_length   in   3   byte count, 1..4
//  io_write_data     in   32  write data, LSB-aligned
//  io_write_done     out  1   one-cycle completion pulse
//  wb_adr_o/wb_dat_o out  32  Wishbone address / write data
//  wb_sel_o          out  4   byte lanes
//  wb_we_o,wb_cyc_o,wb_stb_o out 1  stb == cyc always
//  wb_cti_o          out  3   constant 3'b000 (classic)
//  wb_bte_o          out  2   constant 2'b00
//  wb_dat_i          in   32  read data
//  wb_ack_i,wb_err_i,wb_rty_i in 1  cycle terminations
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0. Reset asserted mid-cycle drops cyc on that edge; no done is issued.
//  FSM: IDLE -> BUS1 -> [GAP -> BUS2] -> DONE -> IDLE.
//  - IDLE: sample do. write_do wins if both are set. Latch addr/len/data/dir. Next state BUS1.
//  - Length clamp: len=0 -> no bus cycle, go straight to DONE with read data 0. len>4 -> treated as 4.
//  - Lanes: off=addr[1:0]; ext[7:0]=((1<<len)-1)<<off; sel1=ext[3:0]; sel2=ext[7:4]; split iff sel2!=0.
//  - Addresses: w1={addr[15:2],2'b00}; w2=w1+4, computed on 16 bits so it wraps (0xFFFC+4 -> 0x0000).
//    wb_adr_o=IO_BASE+w.
//  - Write data: s[63:0]={32'b0,data}<<(8*off); BUS1 drives s[31:0], BUS2 drives s[63:32].
//  - BUSn: cyc=stb=1 with adr/sel/we/dat stable until termination.
//    - ack: capture wb_dat_i (reads).
//    - err: capture 32'hFFFF_FFFF (floating bus); write is discarded.
//    - rty: drop cyc for exactly 1 clock, then reissue the same cycle; after MAX_RTY retries the next rty counts as err.
//    - Timeout: TIMEOUT idle clocks -> err.
//    - Terminations are checked in priority order err > ack > rty if asserted together.
//    - After BUS1, go to GAP (cyc=0 for 1 clock) if split, else DONE.
//  - Read result: ({d2,d1}>>(8*off)) with bytes >= len forced to 0. Unsplit: d2=0.
//  - DONE: pulse the matching *_done for 1 clock; io_read_data holds its value until the next read's DONE.
//    do is ignored in DONE; IDLE re-samples on the following clock.
//  - Latency, zero-wait slave (ack the clock after cyc rises): unsplit done 3 clocks after do sampled;
//    split done 5 clocks after do sampled.
// STRUCTURE
//  Include file ao486_io_wb_defs.vh: FSM state encodings, CTI/BTE constants, FLOAT_DATA=32'hFFFF_FFFF.
//  One combinational sub-module io_lane_align: (addr[1:0], len, wdata, d1, d2) -> sel1, sel2, split, wdat1, wdat2, rdata.
//  Top level holds the FSM, retry and timeout counters, and output registers.
// TESTING (bench: this block driving wb_bfm_memory, plus an err/rty/stall-injecting slave)
//  1. Preload mem[0x60]=32'h44332211. Read addr 0x0061, len 2 -> one cycle, adr 0x60, sel 4'b0110; io_read_data=32'h0000_3322.
//  2. Write addr 0x0063, len 4, data 32'hDDCCBBAA -> two cycles:
//     adr 0x60 sel 4'b1000 dat 32'hAA00_0000, then adr 0x64 sel 4'b0111 dat 32'h00DD_CCBB; one io_write_done pulse.
//  3. Read addr 0xFFFE, len 4 -> adr 0xFFFC sel 4'b1100, then adr 0x0000 sel 4'b0011; bytes are assembled correctly.
//  4. Slave asserts rty twice, then ack -> cyc low 1 clock between attempts, 3 identical cycles, data correct.
//     Slave asserts rty 4 times -> result 32'h0000_FFFF for a len 2 read.
//  5. Stalled slave on a len 1 read -> cyc drops after 255 clocks; io_read_data=32'h0000_00FF; done pulses once.
//  6. Reset asserted during BUS1 -> cyc=0 and all outputs 0 after the edge, no done. Next read completes normally.
//     Also: read_do and write_do asserted together -> write served first, then the read.

Source files
------------

// File: rtl/ao486_io_wb_bridge_pkg.sv
`default_nettype none
//==============================================================================
// ao486_io_wb_bridge_pkg : shared FSM encoding, Wishbone constants, length clamp
// Revision: 1.0
//==============================================================================
package ao486_io_wb_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_BUS1 = 3'd1,
      ST_GAP  = 3'd2,
      ST_BUS2 = 3'd3,
      ST_RTY  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [2:0]  CTI_CLASSIC = 3'b000;
   localparam logic [1:0]  BTE_LINEAR  = 2'b00;
   localparam logic [31:0] FLOAT_DATA  = 32'hFFFF_FFFF;

   // Byte counts above 4 behave as a full dword; 0 stays 0 (no bus cycle).
   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      return (len > 3'd4) ? 3'd4 : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ao486_io_wb_bridge_lane_align.sv
`default_nettype none
//==============================================================================
// io_lane_align : byte-lane steering for writes and result assembly for reads
// Revision: 1.0
//==============================================================================
module io_lane_align
   import ao486_io_wb_bridge_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [2:0]  len_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] d1_i,
   input  logic [23:0] d2_i,
   output logic [3:0]  sel1_o,
   output logic [3:0]  sel2_o,
   output logic        split_o,
   output logic [31:0] wdat1_o,
   output logic [31:0] wdat2_o,
   output logic [31:0] rdata_o
);

   logic [3:0]  mask;
   logic [7:0]  ext;
   logic [63:0] wide;
   logic [31:0] rd;
   logic [5:0]  sh;

   always_comb begin
      case (len_i)
         3'd0:    mask = 4'b0000;
         3'd1:    mask = 4'b0001;
         3'd2:    mask = 4'b0011;
         3'd3:    mask = 4'b0111;
         default: mask = 4'b1111;
      endcase

      sh   = {off_i, 3'b000};
      ext  = {4'b0000, mask} << off_i;
      wide = {32'h0000_0000, wdata_i} << sh;

      // Only the low three bytes of the second dword can ever reach the result.
      case (off_i)
         2'd0:    rd = d1_i;
         2'd1:    rd = {d2_i[7:0],  d1_i[31:8]};
         2'd2:    rd = {d2_i[15:0], d1_i[31:16]};
         default: rd = {d2_i[23:0], d1_i[31:24]};
      endcase

      sel1_o  = ext[3:0];
      sel2_o  = ext[7:4];
      split_o = |ext[7:4];
      wdat1_o = wide[31:0];
      wdat2_o = wide[63:32];

      rdata_o = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         rdata_o[8*i +: 8] = mask[i] ? rd[8*i +: 8] : 8'h00;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ao486_io_wb_bridge.sv
`default_nettype none
//==============================================================================
// ao486_io_wb_bridge : ao486 port-I/O to 32-bit Wishbone classic master bridge
// Revision: 1.0
//==============================================================================
module ao486_io_wb_bridge
   import ao486_io_wb_bridge_pkg::*;
#(
   parameter logic [31:0] IO_BASE = 32'h0000_0000,
   parameter int          MAX_RTY = 3,
   parameter int          TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,

   input  logic        io_read_do,
   input  logic [15:0] io_read_address,
   input  logic [2:0]  io_read_length,
   output logic [31:0] io_read_data,
   output logic        io_read_done,

   input  logic        io_write_do,
   input  logic [15:0] io_write_address,
   input  logic [2:0]  io_write_length,
   input  logic [31:0] io_write_data,
   output logic        io_write_done,

   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic [2:0]  wb_cti_o,
   output logic [1:0]  wb_bte_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i
);

   localparam logic [7:0] RTY_LIMIT = 8'(MAX_RTY);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic        phase2_q;
   logic        we_q;
   logic [15:0] addr_q;
   logic [2:0]  len_q;
   logic [31:0] wdata_q;
   logic [31:0] d1_q;
   logic [23:0] d2_q;
   logic [7:0]  rty_cnt_q;
   logic [7:0]  tmo_q;

   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic [3:0]  sel_q;
   logic        wbwe_q;
   logic        cyc_q;
   logic [31:0] rdata_q;
   logic        rdone_q;
   logic        wdone_q;

   logic        req_we_d;
   logic [15:0] req_addr_d;
   logic [2:0]  req_len_d;
   logic [15:0] cur_addr_d;
   logic [2:0]  cur_len_d;
   logic [31:0] cur_data_d;
   logic [15:0] word1_d;
   logic [15:0] word2_d;
   logic        term_ok_d;
   logic        term_rty_d;
   logic        term_fail_d;
   logic        term_retry_d;
   logic [31:0] cap_data_d;

   logic [3:0]  sel1;
   logic [3:0]  sel2;
   logic        split;
   logic [31:0] wdat1;
   logic [31:0] wdat2;
   logic [31:0] rdata;

   always_comb begin
      req_we_d   = io_write_do;
      req_addr_d = io_write_do ? io_write_address : io_read_address;
      req_len_d  = clamp_len(io_write_do ? io_write_length : io_read_length);

      // In IDLE the first bus phase is built straight from the incoming request.
      cur_addr_d = (state_q == ST_IDLE) ? req_addr_d    : addr_q;
      cur_len_d  = (state_q == ST_IDLE) ? req_len_d     : len_q;
      cur_data_d = (state_q == ST_IDLE) ? io_write_data : wdata_q;

      word1_d = {cur_addr_d[15:2], 2'b00};
      word2_d = word1_d + 16'd4;

      term_ok_d    = wb_ack_i && !wb_err_i;
      term_rty_d   = wb_rty_i && !wb_ack_i && !wb_err_i;
      term_retry_d = term_rty_d && (rty_cnt_q < RTY_LIMIT);
      term_fail_d  = wb_err_i
                   || (term_rty_d && (rty_cnt_q >= RTY_LIMIT))
                   || (!wb_err_i && !wb_ack_i && !wb_rty_i && (tmo_q >= TMO_LAST));
      cap_data_d   = term_ok_d ? wb_dat_i : FLOAT_DATA;
   end

   io_lane_align u_lane (
      .off_i   (cur_addr_d[1:0]),
      .len_i   (cur_len_d),
      .wdata_i (cur_data_d),
      .d1_i    (d1_q),
      .d2_i    (d2_q),
      .sel1_o  (sel1),
      .sel2_o  (sel2),
      .split_o (split),
      .wdat1_o (wdat1),
      .wdat2_o (wdat2),
      .rdata_o (rdata)
   );

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q   <= ST_IDLE;
         phase2_q  <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 16'h0000;
         len_q     <= 3'd0;
         wdata_q   <= 32'h0000_0000;
         d1_q      <= 32'h0000_0000;
         d2_q      <= 24'h00_0000;
         rty_cnt_q <= 8'h00;
         tmo_q     <= 8'h00;
         adr_q     <= 32'h0000_0000;
         dat_q     <= 32'h0000_0000;
         sel_q     <= 4'b0000;
         wbwe_q    <= 1'b0;
         cyc_q     <= 1'b0;
         rdata_q   <= 32'h0000_0000;
         rdone_q   <= 1'b0;
         wdone_q   <= 1'b0;
      end else begin
         rdone_q <= 1'b0;
         wdone_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               // The cycle showing done still sees the old request level; skip it.
               if (!rdone_q && !wdone_q && (io_read_do || io_write_do)) begin
                  we_q      <= req_we_d;
                  addr_q    <= req_addr_d;
                  len_q     <= req_len_d;
                  wdata_q   <= io_write_data;
                  d1_q      <= 32'h0000_0000;
                  d2_q      <= 24'h00_0000;
                  rty_cnt_q <= 8'h00;
                  tmo_q     <= 8'h00;
                  phase2_q  <= 1'b0;
                  if (req_len_d == 3'd0) begin
                     state_q <= ST_DONE;
                  end else begin
                     cyc_q   <= 1'b1;
                     adr_q   <= IO_BASE + {16'h0000, word1_d};
                     sel_q   <= sel1;
                     wbwe_q  <= req_we_d;
                     dat_q   <= wdat1;
                     state_q <= ST_BUS1;
                  end
               end
            end

            ST_BUS1, ST_BUS2: begin
               if (term_ok_d || term_fail_d) begin
                  cyc_q     <= 1'b0;
                  rty_cnt_q <= 8'h00;
                  tmo_q     <= 8'h00;
                  if (state_q == ST_BUS1) begin
                     d1_q    <= cap_data_d;
                     state_q <= split ? ST_GAP : ST_DONE;
                  end else begin
                     d2_q    <= cap_data_d[23:0];
                     state_q <= ST_DONE;
                  end
               end else if (term_retry_d) begin
                  cyc_q     <= 1'b0;
                  rty_cnt_q <= rty_cnt_q + 8'd1;
                  tmo_q     <= 8'h00;
                  phase2_q  <= (state_q == ST_BUS2);
                  state_q   <= ST_RTY;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end

            ST_GAP: begin
               cyc_q   <= 1'b1;
               adr_q   <= IO_BASE + {16'h0000, word2_d};
               sel_q   <= sel2;
               dat_q   <= wdat2;
               state_q <= ST_BUS2;
            end

            ST_RTY: begin
               cyc_q   <= 1'b1;
               state_q <= phase2_q ? ST_BUS2 : ST_BUS1;
            end

            ST_DONE: begin
               if (we_q) begin
                  wdone_q <= 1'b1;
               end else begin
                  rdone_q <= 1'b1;
                  rdata_q <= rdata;
               end
               state_q <= ST_IDLE;
            end

            default: begin
               cyc_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign io_read_data  = rdata_q;
   assign io_read_done  = rdone_q;
   assign io_write_done = wdone_q;

   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;
   assign wb_we_o  = wbwe_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_cti_o = CTI_CLASSIC;
   assign wb_bte_o = BTE_LINEAR;

endmodule
`default_nettype wire

// File: tb/tb_ao486_io_wb_bridge.sv
`default_nettype none
//==============================================================================
// tb_ao486_io_wb_bridge : scoreboard bench with err/rty/stall-injecting memory slave
// Revision: 1.0
//==============================================================================
module tb_ao486_io_wb_bridge;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rd_do, wr_do, rd_done, wr_done;
   logic [15:0] rd_addr, wr_addr;
   logic [2:0]  rd_len, wr_len;
   logic [31:0] rd_data, wr_data;
   logic [31:0] adr, dat_o, sdat;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, err, rty;
   logic [2:0]  cti;
   logic [1:0]  bte;

   ao486_io_wb_bridge dut (
      .wb_clk_i         (clk),
      .wb_rst_n_i       (rst_n),
      .io_read_do       (rd_do),
      .io_read_address  (rd_addr),
      .io_read_length   (rd_len),
      .io_read_data     (rd_data),
      .io_read_done     (rd_done),
      .io_write_do      (wr_do),
      .io_write_address (wr_addr),
      .io_write_length  (wr_len),
      .io_write_data    (wr_data),
      .io_write_done    (wr_done),
      .wb_adr_o         (adr),
      .wb_dat_o         (dat_o),
      .wb_sel_o         (sel),
      .wb_we_o          (we),
      .wb_cyc_o         (cyc),
      .wb_stb_o         (stb),
      .wb_cti_o         (cti),
      .wb_bte_o         (bte),
      .wb_dat_i         (sdat),
      .wb_ack_i         (ack),
      .wb_err_i         (err),
      .wb_rty_i         (rty)
   );

   typedef struct packed {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] dat;
   } bus_t;

   bus_t        exp_bus_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] mem [0:16383];
   bus_t        slv_e;

   int total = 0;
   int bad   = 0;
   int rty_left = 0, err_left = 0, rty_seen = 0, gap_chk = 0, stall_cnt = 0;
   bit stall = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave responds mid-cycle so the bridge sees the termination on the next rising edge.
   always @(negedge clk) begin
      ack  = 1'b0;
      err  = 1'b0;
      rty  = 1'b0;
      sdat = 32'h0;
      if (gap_chk == 1) begin
         check("rty_gap", cyc, 1'b0);
         gap_chk = 2;
      end else if (gap_chk == 2) begin
         check("rty_reissue", cyc, 1'b1);
         gap_chk = 0;
      end
      if (rst_n && cyc) begin
         if (stall) begin
            stall_cnt++;
         end else begin
            check("stb_with_cyc", stb, 1'b1);
            check("bus_queue_nonempty", (exp_bus_q.size() != 0), 1'b1);
            if (exp_bus_q.size() != 0) begin
               slv_e = exp_bus_q.pop_front();
               check("adr", adr, slv_e.adr);
               check("sel", sel, slv_e.sel);
               check("we", we, slv_e.we);
               if (slv_e.we) check("wdat", dat_o, slv_e.dat);
            end
            if (err_left > 0) begin
               err = 1'b1;
               err_left--;
               rty_seen = 0;
            end else if (rty_left > 0) begin
               rty = 1'b1;
               rty_left--;
               if (rty_seen < 3) gap_chk = 1;
               rty_seen++;
            end else begin
               ack = 1'b1;
               rty_seen = 0;
               if (we) begin
                  for (int l = 0; l < 4; l++)
                     if (sel[l]) mem[adr[15:2]][8*l +: 8] = dat_o[8*l +: 8];
               end else begin
                  sdat = mem[adr[15:2]];
               end
            end
         end
      end
   end

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      logic [31:0] w;
      w = mem[a[15:2]];
      return w[8*a[1:0] +: 8];
   endfunction

   // Byte-wise reference: walk each byte address, group by dword, collect lanes.
   task automatic push_model(input bit wr, input logic [15:0] a, input logic [2:0] len,
                             input logic [31:0] data, input int reps);
      int          n;
      bus_t        c;
      logic [15:0] ba;
      logic [31:0] d;
      bit          have;
      n = (len > 3'd4) ? 4 : int'(len);
      d = 32'h0;
      have = 1'b0;
      c = '0;
      for (int i = 0; i < n; i++) begin
         ba = a + 16'(i);
         if (!have || (ba[15:2] != c.adr[15:2])) begin
            if (have) repeat (reps) exp_bus_q.push_back(c);
            c = '0;
            c.adr = {16'h0, ba[15:2], 2'b00};
            c.we = wr;
            have = 1'b1;
         end
         c.sel[ba[1:0]] = 1'b1;
         c.dat[8*ba[1:0] +: 8] = data[8*i +: 8];
         d[8*i +: 8] = mem_byte(ba);
      end
      if (have) repeat (reps) exp_bus_q.push_back(c);
      if (!wr) exp_rd_q.push_back(d);
   endtask

   task automatic run_io(input bit wr, input logic [15:0] a, input logic [2:0] len,
                         input logic [31:0] data, input int exp_lat);
      int          lat;
      bit          seen;
      logic [31:0] e;
      @(negedge clk);
      if (wr) begin
         wr_addr = a; wr_len = len; wr_data = data; wr_do = 1'b1;
      end else begin
         rd_addr = a; rd_len = len; rd_do = 1'b1;
      end
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 2000) begin
         @(negedge clk);
         lat++;
         seen = wr ? wr_done : rd_done;
      end
      check("done_seen", seen, 1'b1);
      if (seen) begin
         if (exp_lat > 0) check("latency", lat, exp_lat);
         check("other_done", wr ? rd_done : wr_done, 1'b0);
         if (!wr) begin
            if (exp_rd_q.size() > 0) e = exp_rd_q.pop_front();
            else e = 32'hx;
            check("rdata", rd_data, e);
         end
      end
      rd_do = 1'b0;
      wr_do = 1'b0;
      @(negedge clk);
      check("done_pulse", {rd_done, wr_done}, 2'b00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  seen;
      logic [31:0] e;
      rst_n = 1'b0;
      rd_do = 1'b0; wr_do = 1'b0;
      rd_addr = 16'h0; wr_addr = 16'h0;
      rd_len = 3'd0; wr_len = 3'd0; wr_data = 32'h0;
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      mem[16'h0060 >> 2] = 32'h4433_2211;
      mem[16'hFFFC >> 2] = 32'h8765_4321;
      mem[0]             = 32'h0FED_CBA9;
      mem[16'h0100 >> 2] = 32'hA5A5_A5A5;
      mem[16'h0200 >> 2] = 32'h7654_3210;

      repeat (3) @(negedge clk);
      check("rst_adr_dat", {adr, dat_o}, 64'h0);
      check("rst_ctl", {sel, we, cyc, stb, cti, bte, rd_done, wr_done, rd_data}, 64'h0);
      rst_n = 1'b1;

      // Unaligned read within one dword.
      push_model(0, 16'h0061, 3'd2, 32'h0, 1);
      run_io(0, 16'h0061, 3'd2, 32'h0, 3);

      // Write crossing a dword boundary.
      push_model(1, 16'h0063, 3'd4, 32'hDDCC_BBAA, 1);
      run_io(1, 16'h0063, 3'd4, 32'hDDCC_BBAA, 5);
      check("mem60", mem[16'h0060 >> 2], 32'hAA33_2211);
      check("mem64", mem[16'h0064 >> 2], 32'h00DD_CCBB);
      push_model(0, 16'h0063, 3'd4, 32'h0, 1);
      run_io(0, 16'h0063, 3'd4, 32'h0, 5);

      // Split read wrapping the 16-bit port space.
      push_model(0, 16'hFFFE, 3'd4, 32'h0, 1);
      run_io(0, 16'hFFFE, 3'd4, 32'h0, 5);

      // Two retries then ack.
      rty_seen = 0;
      rty_left = 2;
      push_model(0, 16'h0061, 3'd2, 32'h0, 3);
      run_io(0, 16'h0061, 3'd2, 32'h0, 0);
      check("rty_consumed", rty_left, 0);

      // Retries exhausted: fourth rty becomes an error.
      rty_seen = 0;
      rty_left = 4;
      push_model(0, 16'h0061, 3'd2, 32'h0, 4);
      exp_rd_q[exp_rd_q.size() - 1] = 32'h0000_FFFF;
      run_io(0, 16'h0061, 3'd2, 32'h0, 0);
      rty_left = 0;

      // Stalled slave hits the bus timeout.
      stall = 1'b1;
      stall_cnt = 0;
      exp_rd_q.push_back(32'h0000_00FF);
      run_io(0, 16'h0010, 3'd1, 32'h0, 0);
      check("tmo_clocks", stall_cnt, 255);
      stall = 1'b0;

      // Length boundaries: 0 issues no bus cycle, 7 behaves as 4.
      push_model(0, 16'h0061, 3'd0, 32'h0, 1);
      run_io(0, 16'h0061, 3'd0, 32'h0, 0);
      push_model(0, 16'h0060, 3'd7, 32'h0, 1);
      run_io(0, 16'h0060, 3'd7, 32'h0, 0);

      // Error on write leaves memory untouched; error on read floats the bus.
      err_left = 1;
      push_model(1, 16'h0100, 3'd1, 32'h0000_005A, 1);
      run_io(1, 16'h0100, 3'd1, 32'h0000_005A, 0);
      check("err_write_discard", mem[16'h0100 >> 2], 32'hA5A5_A5A5);
      err_left = 1;
      push_model(0, 16'h0101, 3'd3, 32'h0, 1);
      exp_rd_q[exp_rd_q.size() - 1] = 32'h00FF_FFFF;
      run_io(0, 16'h0101, 3'd3, 32'h0, 0);

      // Reset during BUS1.
      stall = 1'b1;
      @(negedge clk);
      rd_addr = 16'h0061; rd_len = 3'd2; rd_do = 1'b1;
      repeat (3) @(negedge clk);
      check("cyc_before_rst", cyc, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_adr_dat", {adr, dat_o}, 64'h0);
      check("rstmid_ctl", {sel, we, cyc, stb, rd_done, wr_done, rd_data}, 64'h0);
      rd_do = 1'b0;
      stall = 1'b0;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("no_done_after_rst", {rd_done, wr_done, cyc}, 3'b000);
      end
      push_model(0, 16'h0061, 3'd2, 32'h0, 1);
      run_io(0, 16'h0061, 3'd2, 32'h0, 3);

      // Simultaneous requests: write first, then the read sees the written bytes.
      @(negedge clk);
      push_model(1, 16'h0200, 3'd2, 32'h0000_BEEF, 1);
      wr_addr = 16'h0200; wr_len = 3'd2; wr_data = 32'h0000_BEEF; wr_do = 1'b1;
      rd_addr = 16'h0200; rd_len = 3'd4; rd_do = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin
         @(negedge clk);
         n++;
         seen = wr_done;
         check("both_read_not_first", rd_done, 1'b0);
      end
      check("both_wr_done_seen", seen, 1'b1);
      wr_do = 1'b0;
      push_model(0, 16'h0200, 3'd4, 32'h0, 1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin
         @(negedge clk);
         n++;
         seen = rd_done;
      end
      check("both_rd_done_seen", seen, 1'b1);
      if (exp_rd_q.size() > 0) e = exp_rd_q.pop_front();
      else e = 32'hx;
      check("both_rdata", rd_data, e);
      check("both_rdata_value", rd_data, 32'h7654_BEEF);
      rd_do = 1'b0;
      repeat (2) @(negedge clk);

      check("bus_queue_drained", exp_bus_q.size(), 0);
      check("rd_queue_drained", exp_rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
